// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: writeback controller for the 32 x XLEN register file.
// Round-robin arbitration between the ALU and LSU writeback paths feeds a
// one-entry output stage that drives the register-file write port. A
// pending-write scoreboard answers read-after-write queries from issue.
// Optional feature macro: RF_BYPASS_EN forwards the output-stage write to
// the issue-stage source queries and suppresses the matching busy flag.
//
// Handshake: a transfer completes on a rising edge where valid && ready are
// both high. A requester holds valid, rd and data stable until it sees ready.
// Ready is combinational from the two valids and the round-robin pointer,
// and is only raised for a requester that is currently valid.
module rf_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            sb_set,
    input  logic [4:0]      sb_rd,
    input  logic [4:0]      rs0,
    input  logic [4:0]      rs1,
    output logic            rs0_busy,
    output logic            rs1_busy,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            sb_err,
    output logic            byp0_hit,
    output logic            byp1_hit,
    output logic [XLEN-1:0] byp0_data,
    output logic [XLEN-1:0] byp1_data,
    output logic            dbg_last
);

    // Round-robin pointer: which requester completed the most recent handshake.
    typedef enum logic {
        LAST_ALU = 1'b0,
        LAST_LSU = 1'b1
    } last_t;

    last_t           last;
    logic [31:0]     pending;
    logic [31:0]     pend_next;
    logic            acc_alu;
    logic            acc_lsu;
    logic            acc;
    logic [4:0]      acc_rd;
    logic [XLEN-1:0] acc_data;

    assign dbg_last = last;

    // Grant: a lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        alu_ready = alu_valid && (!lsu_valid || (last == LAST_LSU));
        lsu_ready = lsu_valid && (!alu_valid || (last == LAST_ALU));
        acc_alu   = alu_valid && alu_ready;
        acc_lsu   = lsu_valid && lsu_ready;
        acc       = acc_alu || acc_lsu;
        acc_rd    = acc_alu ? alu_rd   : lsu_rd;
        acc_data  = acc_alu ? alu_data : lsu_data;
    end

    // Scoreboard next state: retire the output-stage write, then apply issue's
    // set so that a set and clear of the same register at one edge leaves it set.
    always_comb begin
        pend_next = pending;
        if (rf_wr_en) begin
            pend_next[rf_wr_addr] = 1'b0;
        end
        if (sb_set && (sb_rd != 5'd0)) begin
            pend_next[sb_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Round-robin pointer advances on every completed handshake.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            last <= LAST_LSU;
        end else if (acc) begin
            last <= acc_alu ? LAST_ALU : LAST_LSU;
        end
    end

    // Output stage: loads an accepted non-x0 write and drains every cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= 5'd0;
            rf_wdata   <= '0;
        end else begin
            rf_wr_en <= acc && (acc_rd != 5'd0);
            if (acc && (acc_rd != 5'd0)) begin
                rf_wr_addr <= acc_rd;
                rf_wdata   <= acc_data;
            end
        end
    end

    // Pending bits and the sticky error for writes to non-pending registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= pend_next;
            if (acc && (acc_rd != 5'd0) && !pending[acc_rd]) begin
                sb_err <= 1'b1;
            end
        end
    end

`ifdef RF_BYPASS_EN
    // Forward the in-flight write so a dependent source is not reported busy.
    always_comb begin
        byp0_hit  = rf_wr_en && (rf_wr_addr == rs0) && (rs0 != 5'd0);
        byp1_hit  = rf_wr_en && (rf_wr_addr == rs1) && (rs1 != 5'd0);
        byp0_data = rf_wdata;
        byp1_data = rf_wdata;
        rs0_busy  = pending[rs0] && !byp0_hit;
        rs1_busy  = pending[rs1] && !byp1_hit;
    end
`else
    // No forwarding: busy is the raw pending bit until the write retires.
    always_comb begin
        byp0_hit  = 1'b0;
        byp1_hit  = 1'b0;
        byp0_data = '0;
        byp1_data = '0;
        rs0_busy  = pending[rs0];
        rs1_busy  = pending[rs1];
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed steps followed by randomized traffic,
// checked against a behavioural model of the writeback rules.
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            aresetn;
    logic            alu_valid, alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            sb_set;
    logic [4:0]      sb_rd;
    logic [4:0]      rs0, rs1;
    logic            rs0_busy, rs1_busy;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wdata;
    logic            sb_err;
    logic            byp0_hit, byp1_hit;
    logic [XLEN-1:0] byp0_data, byp1_data;
    logic            dbg_last;

    rf_wb_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .aresetn(aresetn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .sb_set(sb_set), .sb_rd(sb_rd), .rs0(rs0), .rs1(rs1),
        .rs0_busy(rs0_busy), .rs1_busy(rs1_busy),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wdata(rf_wdata),
        .sb_err(sb_err), .byp0_hit(byp0_hit), .byp1_hit(byp1_hit),
        .byp0_data(byp0_data), .byp1_data(byp1_data), .dbg_last(dbg_last)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counters and reference model state
    int n_checks = 0;
    int n_errors = 0;

    bit          m_pend[32];     // registers with an outstanding write
    bit          m_alu_won_last; // ALU completed the most recent handshake
    bit          m_err;
    bit          m_acc_alu;
    bit          m_acc_lsu;
    logic [36:0] exp_q[$];       // {addr, data} of the write in flight to the RF
    bit          prev_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_alu_won_last = 1'b0;
        m_err          = 1'b0;
        m_acc_alu      = 1'b0;
        m_acc_lsu      = 1'b0;
        exp_q.delete();
    endtask

    function automatic bit want_alu();
        return (alu_valid === 1'b1) && (lsu_valid !== 1'b1 || m_alu_won_last == 1'b0);
    endfunction

    function automatic bit want_lsu();
        return (lsu_valid === 1'b1) && (alu_valid !== 1'b1 || m_alu_won_last == 1'b1);
    endfunction

    // Compare every output against the model (called away from the clock edge)
    task automatic check_all();
        bit          s_v;
        logic [4:0]  sa;
        logic [31:0] sd;
        bit          h0, h1;
        s_v = (exp_q.size() != 0);
        sa  = 5'd0;
        sd  = 32'd0;
        if (s_v) begin
            sa = exp_q[0][36:32];
            sd = exp_q[0][31:0];
        end
        check("alu_ready", 32'(alu_ready), 32'(want_alu()));
        check("lsu_ready", 32'(lsu_ready), 32'(want_lsu()));
        check("rf_wr_en", 32'(rf_wr_en), 32'(s_v));
        if (s_v) begin
            check("rf_wr_addr", 32'(rf_wr_addr), 32'(sa));
            check("rf_wdata", rf_wdata, sd);
        end
`ifdef RF_BYPASS_EN
        h0 = s_v && (sa == rs0) && (rs0 != 5'd0);
        h1 = s_v && (sa == rs1) && (rs1 != 5'd0);
        check("byp0_hit", 32'(byp0_hit), 32'(h0));
        check("byp1_hit", 32'(byp1_hit), 32'(h1));
        if (h0) check("byp0_data", byp0_data, sd);
        if (h1) check("byp1_data", byp1_data, sd);
`else
        h0 = 1'b0;
        h1 = 1'b0;
        check("byp0_hit", 32'(byp0_hit), 32'd0);
        check("byp1_hit", 32'(byp1_hit), 32'd0);
        check("byp0_data", byp0_data, 32'd0);
        check("byp1_data", byp1_data, 32'd0);
`endif
        check("rs0_busy", 32'(rs0_busy), 32'(m_pend[rs0] && !h0));
        check("rs1_busy", 32'(rs1_busy), 32'(m_pend[rs1] && !h1));
        check("sb_err", 32'(sb_err), 32'(m_err));
    endtask

    // Apply one clock edge of writeback rules to the model
    task automatic model_update();
        logic [4:0]  rd;
        logic [31:0] data;
        m_acc_alu = want_alu();
        m_acc_lsu = want_lsu();
        rd   = m_acc_alu ? alu_rd : lsu_rd;
        data = m_acc_alu ? alu_data : lsu_data;
        if ((m_acc_alu || m_acc_lsu) && rd != 5'd0 && !m_pend[rd]) m_err = 1'b1;
        if (m_acc_alu || m_acc_lsu) m_alu_won_last = m_acc_alu;
        if (exp_q.size() != 0) begin
            m_pend[exp_q[0][36:32]] = 1'b0;
            exp_q.delete();
        end
        if (sb_set && sb_rd != 5'd0) m_pend[sb_rd] = 1'b1;
        if ((m_acc_alu || m_acc_lsu) && rd != 5'd0) exp_q.push_back({rd, data});
    endtask

    // Driver tasks
    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;
        sb_set = 1'b0; sb_rd = 5'd0; rs0 = 5'd0; rs1 = 5'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #3 aresetn = 1'b1;
        #1;
        check("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
        check("rst_sb_err", 32'(sb_err), 32'd0);
        check("rst_last_is_lsu", 32'(dbg_last), 32'd1);
    endtask

    task automatic set_pending(input logic [4:0] r);
        sb_set = 1'b1; sb_rd = r;
        tick();
        sb_set = 1'b0;
    endtask

    // Stimulus
    initial begin
        aresetn = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();

        // Single ALU write to a pending register
        set_pending(5'd5);
        rs0 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 check("t1_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check("t1_wr_en", 32'(rf_wr_en), 32'd1);
        check("t1_wr_addr", 32'(rf_wr_addr), 32'd5);
        check("t1_wdata", rf_wdata, 32'hDEADBEEF);
`ifdef RF_BYPASS_EN
        check("t1_busy_bypassed", 32'(rs0_busy), 32'd0);
`else
        check("t1_busy_inflight", 32'(rs0_busy), 32'd1);
`endif
        tick();
        check("t1_busy_cleared", 32'(rs0_busy), 32'd0);
        check("t1_wr_en_off", 32'(rf_wr_en), 32'd0);
        check("t1_sb_err", 32'(sb_err), 32'd0);

        // Continuous contention: grants alternate, write port busy every cycle
        set_pending(5'd1);
        set_pending(5'd2);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = $urandom;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = $urandom;
        for (int i = 0; i < 8; i++) begin
            sb_set = (exp_q.size() != 0);
            sb_rd  = (exp_q.size() != 0) ? exp_q[0][36:32] : 5'd0;
            #1;
            check("t2_one_grant", 32'(lsu_ready), 32'(!alu_ready));
            if (i > 0) check("t2_alternate", 32'(alu_ready), 32'(!prev_grant));
            prev_grant = alu_ready;
            tick();
            check("t2_wr_en", 32'(rf_wr_en), 32'd1);
            if (m_acc_alu) alu_data = $urandom;
            if (m_acc_lsu) lsu_data = $urandom;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0; sb_set = 1'b0;
        tick();
        check("t2_sb_err", 32'(sb_err), 32'd0);

        // Write to x0: handshake completes, nothing reaches the register file
        rs0 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1 check("t3_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check("t3_wr_en", 32'(rf_wr_en), 32'd0);
        check("t3_sb_err", 32'(sb_err), 32'd0);
        tick();

        // Write to a non-pending register raises the sticky error
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0BAD0007;
        tick();
        lsu_valid = 1'b0;
        check("t4_sb_err_set", 32'(sb_err), 32'd1);
        check("t4_wr_addr", 32'(rf_wr_addr), 32'd7);
        repeat (3) tick();
        check("t4_sb_err_sticky", 32'(sb_err), 32'd1);
        do_reset();

        // Retire and re-set the same register at one edge: set wins
        set_pending(5'd3);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        tick();
        alu_valid = 1'b0;
        sb_set = 1'b1; sb_rd = 5'd3;
        tick();
        sb_set = 1'b0; rs0 = 5'd3;
        #1 check("t5_rs0_busy", 32'(rs0_busy), 32'd1);
        check("t5_sb_err", 32'(sb_err), 32'd0);
        tick();

        // Forwarding of the in-flight write
        set_pending(5'd9);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE0000;
        tick();
        alu_valid = 1'b0; rs1 = 5'd9;
        #1;
`ifdef RF_BYPASS_EN
        check("t6_byp1_hit", 32'(byp1_hit), 32'd1);
        check("t6_byp1_data", byp1_data, 32'hCAFE0000);
        check("t6_rs1_busy", 32'(rs1_busy), 32'd0);
`else
        check("t6_rs1_busy", 32'(rs1_busy), 32'd1);
        check("t6_byp1_hit", 32'(byp1_hit), 32'd0);
`endif
        tick();

        // Asynchronous reset while the output stage holds a write
        set_pending(5'd4);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44444444;
        sb_set = 1'b1; sb_rd = 5'd6;
        tick();
        alu_valid = 1'b0; sb_set = 1'b0;
        check("t7_wr_en_before", 32'(rf_wr_en), 32'd1);
        #2 aresetn = 1'b0;
        idle_inputs();
        model_reset();
        #1 check("t7_wr_en_dropped", 32'(rf_wr_en), 32'd0);
        for (int r = 0; r < 32; r++) begin
            rs0 = 5'(r);
            #1 check("t7_pending_zero", 32'(rs0_busy), 32'd0);
        end
        @(posedge clk);
        #3 aresetn = 1'b1;
        #1 check("t7_last_is_lsu", 32'(dbg_last), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            if (!alu_valid || m_acc_alu) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!lsu_valid || m_acc_lsu) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            sb_set = 1'($urandom_range(0, 1));
            sb_rd  = 5'($urandom_range(0, 7));
            rs0    = 5'($urandom_range(0, 7));
            rs1    = 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
